// File: rtl/ifu_fetch_queue.sv
// Fetch front end: ICache PC, static next-PC prediction, DEPTH-entry queue to decode.
// Define IFQ_STATIC_BPRED_EN for backward-branch / jal prediction; otherwise pc+4.
module ifu_fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic                     clock,
  input  logic                     reset,
  output logic [31:0]              fetch_pc,
  input  logic                     fetch_hit,
  input  logic [31:0]              fetch_inst,
  input  logic                     flush,
  input  logic [31:0]              flush_pc,
  input  logic                     out_ready,
  output logic                     out_valid,
  output logic [31:0]              out_pc,
  output logic [31:0]              out_inst,
  output logic [31:0]              out_pred_npc,
  output logic [$clog2(DEPTH):0]   fq_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] npc;
  } fq_entry_t;

  typedef enum logic {
    S_RUN,
    S_PEND
  } state_t;

  state_t state_q, state_d;
  logic   pending;

  fq_entry_t mem_q [DEPTH];
  fq_entry_t head_e;

  logic [AW-1:0] head_q, tail_q;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   pc_q, pc_d;
  logic [31:0]   pend_pc_q, pend_pc_d;
  logic [31:0]   inc;
  logic [31:0]   pred_npc;
  logic          full;
  logic          enq, deq;

  // Next-PC increment selection
`ifdef IFQ_STATIC_BPRED_EN
  logic [31:0] imm_b, imm_j;
  logic        is_br, is_jal;

  assign imm_b = {{20{fetch_inst[31]}}, fetch_inst[7],
                  fetch_inst[30:25], fetch_inst[11:8], 1'b0};
  assign imm_j = {{12{fetch_inst[31]}}, fetch_inst[19:12],
                  fetch_inst[20], fetch_inst[30:21], 1'b0};
  assign is_br  = (fetch_inst[6:2] == 5'b11000) & fetch_inst[31];
  assign is_jal = (fetch_inst[6:2] == 5'b11011);

  always_comb begin
    inc = 32'd4;
    unique case (1'b1)
      is_br:   inc = imm_b;
      is_jal:  inc = imm_j;
      default: inc = 32'd4;
    endcase
  end
`else
  assign inc = 32'd4;
`endif

  assign pred_npc = pc_q + inc;

  assign head_e    = mem_q[head_q];
  assign full      = (count_q == CW'(DEPTH));
  assign out_valid = (count_q != '0) & ~flush;
  assign deq       = out_valid & out_ready;
  assign enq       = fetch_hit & ~pending & ~flush & (~full | deq);

  assign out_pc       = head_e.pc;
  assign out_inst     = head_e.inst;
  assign out_pred_npc = head_e.npc;
  assign fq_count     = count_q;
  assign fetch_pc     = pc_q;

  // Redirect FSM: state register
  always_ff @(posedge clock) begin
    if (reset) state_q <= S_RUN;
    else       state_q <= state_d;
  end

  // Redirect FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_RUN:   if (flush & ~fetch_hit) state_d = S_PEND;
      S_PEND:  if (fetch_hit)          state_d = S_RUN;
      default: state_d = S_RUN;
    endcase
  end

  // Redirect FSM: outputs
  always_comb begin
    pending = (state_q == S_PEND);
  end

  // A miss stays addressed until it returns; the redirect is parked meanwhile
  always_comb begin
    pc_d      = pc_q;
    pend_pc_d = pend_pc_q;
    if (flush) begin
      if (fetch_hit) pc_d      = flush_pc;
      else           pend_pc_d = flush_pc;
    end else if (pending) begin
      if (fetch_hit) pc_d = pend_pc_q;
    end else if (enq) begin
      pc_d = pred_npc;
    end
  end

  always_comb begin
    count_d = count_q + CW'(enq) - CW'(deq);
    if (flush) count_d = '0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q      <= RESET_PC;
      pend_pc_q <= '0;
      count_q   <= '0;
      head_q    <= '0;
      tail_q    <= '0;
    end else begin
      pc_q      <= pc_d;
      pend_pc_q <= pend_pc_d;
      count_q   <= count_d;
      if (flush) begin
        head_q <= '0;
        tail_q <= '0;
      end else begin
        if (deq) head_q <= head_q + AW'(1);
        if (enq) tail_q <= tail_q + AW'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (enq) mem_q[tail_q] <= '{pc: pc_q, inst: fetch_inst, npc: pred_npc};
  end

endmodule

// File: tb/tb_ifu_fetch_queue.sv
// Scoreboard bench for ifu_fetch_queue: model PC/pending state, expected
// entries queued on enqueue and compared at the head on each output cycle.
module tb_ifu_fetch_queue;

  localparam int          DEPTH  = 4;
  localparam logic [31:0] RST_PC = 32'h8000_0000;
`ifdef IFQ_STATIC_BPRED_EN
  localparam bit BPRED = 1'b1;
`else
  localparam bit BPRED = 1'b0;
`endif
  localparam logic [31:0] BR_NPC = BPRED ? 32'h8000_0004 : 32'h8000_000C;

  logic        clock;
  logic        reset;
  logic [31:0] fetch_pc;
  logic        fetch_hit;
  logic [31:0] fetch_inst;
  logic        flush;
  logic [31:0] flush_pc;
  logic        out_ready;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic [31:0] out_pred_npc;
  logic [2:0]  fq_count;

  ifu_fetch_queue #(
    .DEPTH    (DEPTH),
    .RESET_PC (RST_PC)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .fetch_pc     (fetch_pc),
    .fetch_hit    (fetch_hit),
    .fetch_inst   (fetch_inst),
    .flush        (flush),
    .flush_pc     (flush_pc),
    .out_ready    (out_ready),
    .out_valid    (out_valid),
    .out_pc       (out_pc),
    .out_inst     (out_inst),
    .out_pred_npc (out_pred_npc),
    .fq_count     (fq_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] npc;
  } ent_t;

  ent_t        sb[$];
  logic [31:0] m_pc;
  logic [31:0] m_pend_pc;
  bit          m_pend;
  bit          use_br;
  int          errors;
  int          checks;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] imem(input logic [31:0] a);
    if (use_br && a == 32'h8000_0008) return 32'hFE00_0EE3;
    if (a == 32'h8000_0104) return 32'h0100_006F;
    return 32'h0000_0013;
  endfunction

  function automatic logic [31:0] pred(input logic [31:0] pc,
                                       input logic [31:0] i);
    logic [31:0] off;
    off = 32'd4;
    if (BPRED && i[6:2] == 5'b11000 && i[31])
      off = {{20{i[31]}}, i[7], i[30:25], i[11:8], 1'b0};
    else if (BPRED && i[6:2] == 5'b11011)
      off = {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0};
    return pc + off;
  endfunction

  task automatic step(input bit rst, input bit hit, input bit fl,
                      input logic [31:0] fpc, input bit rdy);
    bit   exp_v;
    bit   deq;
    bit   enq;
    ent_t e;
    @(negedge clock);
    reset      = rst;
    fetch_hit  = hit;
    flush      = fl;
    flush_pc   = fpc;
    out_ready  = rdy;
    fetch_inst = hit ? imem(m_pc) : 32'hDEAD_BEEF;
    #1;
    if (rst) begin
      m_pc   = RST_PC;
      m_pend = 1'b0;
      sb.delete();
      return;
    end
    check("fetch_pc", fetch_pc, m_pc);
    check("fq_count", 32'(fq_count), 32'(sb.size()));
    exp_v = (sb.size() != 0) && !fl;
    check("out_valid", 32'(out_valid), 32'(exp_v));
    if (exp_v) begin
      check("out_pc", out_pc, sb[0].pc);
      check("out_inst", out_inst, sb[0].inst);
      check("out_pred_npc", out_pred_npc, sb[0].npc);
    end
    deq = exp_v && rdy;
    enq = hit && !m_pend && !fl && (sb.size() < DEPTH || deq);
    if (deq) void'(sb.pop_front());
    if (enq) begin
      e.pc   = m_pc;
      e.inst = fetch_inst;
      e.npc  = pred(m_pc, fetch_inst);
      sb.push_back(e);
      m_pc = e.npc;
    end
    if (fl) begin
      sb.delete();
      if (hit) begin
        m_pc   = fpc;
        m_pend = 1'b0;
      end else begin
        m_pend    = 1'b1;
        m_pend_pc = fpc;
      end
    end else if (m_pend && hit) begin
      m_pc   = m_pend_pc;
      m_pend = 1'b0;
    end
  endtask

  task automatic do_reset();
    step(1, 0, 0, '0, 0);
    step(1, 0, 0, '0, 0);
  endtask

  logic [31:0] rpc [4];

  initial begin
    errors     = 0;
    checks     = 0;
    use_br     = 1'b0;
    m_pc       = RST_PC;
    m_pend     = 1'b0;
    m_pend_pc  = '0;
    reset      = 1'b1;
    fetch_hit  = 1'b0;
    fetch_inst = '0;
    flush      = 1'b0;
    flush_pc   = '0;
    out_ready  = 1'b0;
    rpc[0] = 32'h8000_0000;
    rpc[1] = 32'h8000_0100;
    rpc[2] = 32'h8000_0104;
    rpc[3] = 32'h8000_1000;

    // reset state and straight-line streaming
    do_reset();
    step(0, 1, 0, '0, 1);
    check("rst_fetch_pc", fetch_pc, RST_PC);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_count", 32'(fq_count), 32'd0);
    step(0, 1, 0, '0, 1);
    check("first_out_pc", out_pc, 32'h8000_0000);
    step(0, 1, 0, '0, 1);
    check("second_out_pc", out_pc, 32'h8000_0004);
    for (int i = 0; i < 6; i++) step(0, 1, 0, '0, 1);

    // fill with decode stalled, then drain through the full boundary
    do_reset();
    for (int i = 0; i < 6; i++) step(0, 1, 0, '0, 0);
    check("full_count", 32'(fq_count), 32'd4);
    check("full_hold_pc", fetch_pc, 32'h8000_0010);
    step(0, 1, 0, '0, 1);
    step(0, 1, 0, '0, 1);
    check("full_nobubble_cnt", 32'(fq_count), 32'd4);
    check("full_nobubble_pc", out_pc, 32'h8000_0004);
    for (int i = 0; i < 10; i++) step(0, 1, 0, '0, 1);

    // backward branch prediction
    use_br = 1'b1;
    do_reset();
    for (int i = 0; i < 4; i++) step(0, 1, 0, '0, 1);
    check("br_out_pc", out_pc, 32'h8000_0008);
    check("br_pred_npc", out_pred_npc, BR_NPC);
    check("br_fetch_pc", fetch_pc, BR_NPC);
    use_br = 1'b0;

    // flush with hit while three entries queued
    do_reset();
    for (int i = 0; i < 3; i++) step(0, 1, 0, '0, 0);
    step(0, 1, 1, 32'h8000_1000, 0);
    check("fl_valid_masked", 32'(out_valid), 32'd0);
    step(0, 1, 0, '0, 1);
    check("fl_count_zero", 32'(fq_count), 32'd0);
    check("fl_fetch_pc", fetch_pc, 32'h8000_1000);
    step(0, 1, 0, '0, 1);
    check("fl_first_valid", 32'(out_valid), 32'd1);
    check("fl_first_pc", out_pc, 32'h8000_1000);

    // two redirects during one outstanding miss
    do_reset();
    for (int i = 0; i < 3; i++) step(0, 1, 0, '0, 1);
    step(0, 0, 1, 32'h8000_2000, 1);
    step(0, 0, 0, '0, 1);
    step(0, 0, 1, 32'h8000_3000, 1);
    for (int i = 0; i < 4; i++) step(0, 0, 0, '0, 1);
    step(0, 1, 0, '0, 1);
    step(0, 1, 0, '0, 1);
    check("pend_fetch_pc", fetch_pc, 32'h8000_3000);
    check("pend_dropped", 32'(out_valid), 32'd0);
    step(0, 1, 0, '0, 1);
    check("pend_out_pc", out_pc, 32'h8000_3000);

    // reset during a pending redirect
    do_reset();
    step(0, 1, 0, '0, 1);
    step(0, 1, 0, '0, 1);
    step(0, 0, 1, 32'h8000_4000, 1);
    step(0, 0, 0, '0, 1);
    step(1, 0, 0, '0, 0);
    step(0, 0, 0, '0, 1);
    check("rmiss_fetch_pc", fetch_pc, RST_PC);
    check("rmiss_count", 32'(fq_count), 32'd0);
    step(0, 1, 0, '0, 1);
    step(0, 1, 0, '0, 1);
    check("rmiss_no_stale", fetch_pc, 32'h8000_0004);
    step(0, 1, 0, '0, 1);

    // random traffic
    use_br = 1'b1;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      step(0, $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0,
           rpc[$urandom_range(0, 3)], $urandom_range(0, 2) != 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
